// File: rtl/add_num_stream_engine.sv
// add_num_stream_engine: reads num lines from src, adds packed LANE_W operand pairs lane-wise, writes one result line each to dst (ADD_NUM_SATURATE_EN clamps lane sums).
// Latency per line: RD_REQ 1 + response wait + COMPUTE 1 + WR_REQ 1 cycles; done pulses the cycle after the last write.
// Backpressure: rd_almfull_i / wr_almfull_i hold the FSM in RD_REQ / WR_REQ with no request issued; one read outstanding at most.
module add_num_stream_engine #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 42,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [CNT_W-1:0]  num_lines_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  lines_done_o,
  output logic              rd_req_valid_o,
  output logic [ADDR_W-1:0] rd_req_addr_o,
  input  logic              rd_almfull_i,
  input  logic              rd_rsp_valid_i,
  input  logic [DATA_W-1:0] rd_rsp_data_i,
  output logic              wr_req_valid_o,
  output logic [ADDR_W-1:0] wr_req_addr_o,
  output logic [DATA_W-1:0] wr_req_data_o,
  input  logic              wr_almfull_i
);

  localparam int NUM_PAIRS = DATA_W / (2 * LANE_W);
  localparam int PAIR_W    = 2 * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_COMPUTE, ST_WR_REQ, ST_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]    num_q, num_d, idx_q, idx_d;
  logic [CNT_W-1:0]    lines_done_q, lines_done_d;
  logic [DATA_W-1:0]   line_q, line_d, result_q, result_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  // Each pair's sum sits zero-extended in a 2*LANE_W field at the pair's position.
  function automatic logic [DATA_W-1:0] add_lanes(input logic [DATA_W-1:0] line);
    logic [DATA_W-1:0] res;
    logic [LANE_W:0]   sum;
    res = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      sum = {1'b0, line[2*p*LANE_W +: LANE_W]} + {1'b0, line[(2*p+1)*LANE_W +: LANE_W]};
`ifdef ADD_NUM_SATURATE_EN
      if (sum[LANE_W]) sum = {1'b0, {LANE_W{1'b1}}};
`endif
      res[p*PAIR_W +: PAIR_W] = PAIR_W'(sum);
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    num_d        = num_q;
    idx_d        = idx_q;
    lines_done_d = lines_done_q;
    line_d       = line_q;
    result_d     = result_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_vld_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_vld_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d        = src_addr_i;
          dst_d        = dst_addr_i;
          num_d        = num_lines_i;
          idx_d        = '0;
          lines_done_d = '0;
          busy_d       = 1'b1;
          state_d      = (num_lines_i == '0) ? ST_FINISH : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!rd_almfull_i) begin
          rd_vld_d  = 1'b1;
          rd_addr_d = src_q + ADDR_W'(idx_q);
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rd_rsp_valid_i) begin
          line_d  = rd_rsp_data_i;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        result_d = add_lanes(line_q);
        state_d  = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (!wr_almfull_i) begin
          wr_vld_d     = 1'b1;
          wr_addr_d    = dst_q + ADDR_W'(idx_q);
          wr_data_d    = result_q;
          idx_d        = idx_q + CNT_W'(1);
          lines_done_d = lines_done_q + CNT_W'(1);
          state_d      = (idx_d == num_q) ? ST_FINISH : ST_RD_REQ;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      src_q        <= '0;
      dst_q        <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      lines_done_q <= '0;
      line_q       <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_addr_q    <= '0;
      wr_vld_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      src_q        <= src_d;
      dst_q        <= dst_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      lines_done_q <= lines_done_d;
      line_q       <= line_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_vld_q     <= rd_vld_d;
      rd_addr_q    <= rd_addr_d;
      wr_vld_q     <= wr_vld_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign lines_done_o   = lines_done_q;
  assign rd_req_valid_o = rd_vld_q;
  assign rd_req_addr_o  = rd_addr_q;
  assign wr_req_valid_o = wr_vld_q;
  assign wr_req_addr_o  = wr_addr_q;
  assign wr_req_data_o  = wr_data_q;

endmodule
